// File: rtl/am2911_seq_pkg.sv
// Shared constants for the am2911_seq microprogram sequencer: next-address
// source selects and the subroutine-stack operation encoding.
package am2911_seq_pkg;

   localparam logic [1:0] S_UPC = 2'b00;
   localparam logic [1:0] S_REG = 2'b01;
   localparam logic [1:0] S_STK = 2'b10;
   localparam logic [1:0] S_D   = 2'b11;

   typedef enum logic [1:0] {
      STK_HOLD = 2'b00,
      STK_PUSH = 2'b01,
      STK_POP  = 2'b10
   } stk_op_e;

   // The stack file enable and direction come straight from am29811a.
   function automatic stk_op_e stk_op_decode(input logic fe_, input logic pup);
      if (fe_)      return STK_HOLD;
      else if (pup) return STK_PUSH;
      else          return STK_POP;
   endfunction

endpackage

// File: rtl/am2911_seq_stack.sv
// Subroutine LIFO for am2911_seq: DEPTH x WIDTH, wraps and overwrites when full.
// Optional sticky push-while-full / pop-while-empty flag under AM2911_SEQ_STKCHK_EN.
module am2911_seq_stack
   import am2911_seq_pkg::*;
#(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_,
   input  stk_op_e          op,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] tos,
   output logic             empty,
   output logic             full,
   output logic             err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    sp_q, sp_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CNT_FULL);
   assign tos   = empty ? '0 : mem_q[sp_q];

   always_comb begin
      // NOTE: every signal gets a default before the case so no latch is inferred.
      mem_d = mem_q;
      sp_d  = sp_q;
      cnt_d = cnt_q;
      unique case (op)
         STK_PUSH: begin
            sp_d        = sp_q + PW'(1);
            mem_d[sp_d] = din;
            if (!full) cnt_d = cnt_q + CW'(1);
         end
         STK_POP: begin
            if (!empty) begin
               sp_d  = sp_q - PW'(1);
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: ;
      endcase
   end

   // sp starts one below entry 0 so the first push lands in entry 0.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         // NOTE: the stack entries are reset too, so a popped-empty TOS never exposes stale data.
         mem_q <= '{default: '0};
         sp_q  <= '1;
         cnt_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment only.
         mem_q <= mem_d;
         sp_q  <= sp_d;
         cnt_q <= cnt_d;
      end
   end

`ifdef AM2911_SEQ_STKCHK_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q | ((op == STK_PUSH) && full) | ((op == STK_POP) && empty);
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: rtl/am2911_seq.sv
// am2911_seq: microprogram sequencer datapath (address mux, uPC incrementer,
// register R, subroutine stack, loop counter). Optional macro: AM2911_SEQ_STKCHK_EN.
module am2911_seq
   import am2911_seq_pkg::*;
#(
   parameter int WIDTH  = 12,
   parameter int CWIDTH = 12,
   parameter int DEPTH  = 4
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic [1:0]       s,
   input  logic             fe_,
   input  logic             pup,
   input  logic             re_,
   input  logic             zero_,
   input  logic             cin,
   input  logic             cntload_,
   input  logic             cnte_,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] y,
   output logic             cout,
   output logic             ctr_zero,
   output logic             stk_empty,
   output logic             stk_full,
   output logic             stk_err
);

   logic [WIDTH-1:0]  upc_q, upc_d;
   logic [WIDTH-1:0]  r_q, r_d;
   logic [CWIDTH-1:0] ctr_q, ctr_d;
   logic [WIDTH-1:0]  tos;

   am2911_seq_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
      .clk   (clk),
      .rst_  (rst_),
      .op    (stk_op_decode(fe_, pup)),
      .din   (upc_q),
      .tos   (tos),
      .empty (stk_empty),
      .full  (stk_full),
      .err   (stk_err)
   );

   always_comb begin
      y = '0;
      if (zero_) begin
         unique case (s)
            S_UPC:   y = upc_q;
            S_REG:   y = r_q;
            S_STK:   y = tos;
            default: y = d;
         endcase
      end
      {cout, upc_d} = {1'b0, y} + (WIDTH + 1)'(cin);
   end

   always_comb begin
      r_d   = re_ ? r_q : d;
      ctr_d = ctr_q;
      if (!cntload_)   ctr_d = d[CWIDTH-1:0];
      else if (!cnte_) ctr_d = ctr_q - CWIDTH'(1);
   end

   assign ctr_zero = (ctr_q == '0);

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         upc_q <= '0;
         r_q   <= '0;
         ctr_q <= '0;
      end else begin
         upc_q <= upc_d;
         r_q   <= r_d;
         ctr_q <= ctr_d;
      end
   end

endmodule

// File: tb/tb_am2911_seq.sv
// Directed self-checking bench for am2911_seq with hand-computed expectations.
module tb_am2911_seq;

`ifdef AM2911_SEQ_STKCHK_EN
   localparam logic STKCHK = 1'b1;
`else
   localparam logic STKCHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_;
   logic [1:0]  s;
   logic        fe_, pup, re_, zero_, cin, cntload_, cnte_;
   logic [11:0] d;
   logic [11:0] y;
   logic        cout, ctr_zero, stk_empty, stk_full, stk_err;

   int n_tests = 0;
   int n_fail  = 0;

   am2911_seq dut (
      .clk       (clk),
      .rst_      (rst_),
      .s         (s),
      .fe_       (fe_),
      .pup       (pup),
      .re_       (re_),
      .zero_     (zero_),
      .cin       (cin),
      .cntload_  (cntload_),
      .cnte_     (cnte_),
      .d         (d),
      .y         (y),
      .cout      (cout),
      .ctr_zero  (ctr_zero),
      .stk_empty (stk_empty),
      .stk_full  (stk_full),
      .stk_err   (stk_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_ = 1'b0; s = 2'b00; fe_ = 1'b1; pup = 1'b0; re_ = 1'b1; zero_ = 1'b1;
      cin = 1'b0; cntload_ = 1'b1; cnte_ = 1'b1; d = '0;
      #1;
      check("rst_y_upc", y, 0);
      check("rst_ctr_zero", ctr_zero, 1);
      check("rst_empty", stk_empty, 1);
      check("rst_full", stk_full, 0);
      check("rst_err", stk_err, 0);
      s = 2'b01; #1; check("rst_y_reg", y, 0);
      s = 2'b10; #1; check("rst_y_stk", y, 0);
      tick();
      rst_ = 1'b1;

      // Sequential fetch
      s = 2'b00; cin = 1'b1; #1;
      check("fetch0", y, 12'h000);
      for (int i = 1; i <= 6; i++) begin
         tick();
         check($sformatf("fetch%0d", i), y, i);
      end

      // Call from uPC=6 to 0x100
      s = 2'b11; d = 12'h100; fe_ = 1'b0; pup = 1'b1; #1;
      check("call_y", y, 12'h100);
      tick();
      fe_ = 1'b1; s = 2'b00; #1;
      check("call_upc", y, 12'h101);
      s = 2'b10; #1;
      check("call_tos", y, 12'h006);
      check("call_nonempty", stk_empty, 0);

      // Return
      fe_ = 1'b0; pup = 1'b0; #1;
      check("ret_y", y, 12'h006);
      tick();
      fe_ = 1'b1; s = 2'b00; #1;
      check("ret_upc", y, 12'h007);
      check("ret_empty", stk_empty, 1);

      // Register R load; uPC advances 7 -> 8
      re_ = 1'b0; d = 12'h2A5;
      tick();
      re_ = 1'b1; d = 12'h000; s = 2'b01; #1;
      check("reg_r", y, 12'h2A5);
      s = 2'b00; #1;
      check("reg_upc", y, 12'h008);

      // Overflow: pushes store 8,9,A,B then C overwrites the oldest
      fe_ = 1'b0; pup = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check("ovf_full4", stk_full, 1);
      check("ovf_err4", stk_err, 0);
      tick();
      fe_ = 1'b1; #1;
      check("ovf_full5", stk_full, 1);
      check("ovf_err5", stk_err, STKCHK);
      s = 2'b10; #1;
      check("ovf_tos5", y, 12'h00C);
      fe_ = 1'b0; pup = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("pop%0d_y", i), y, 12'h00C - i);
         tick();
      end
      check("pop_empty", stk_empty, 1);
      check("pop_empty_tos", y, 0);
      tick();
      fe_ = 1'b1; #1;
      check("underflow_empty", stk_empty, 1);
      check("underflow_full", stk_full, 0);
      check("underflow_err", stk_err, STKCHK);

      // Loop counter
      s = 2'b00; cntload_ = 1'b0; d = 12'h003;
      tick();
      cntload_ = 1'b1; #1;
      check("ctr_load3", ctr_zero, 0);
      cnte_ = 1'b0;
      tick(); tick();
      check("ctr_at1", ctr_zero, 0);
      tick();
      check("ctr_at0", ctr_zero, 1);
      tick();
      check("ctr_wrap", ctr_zero, 0);
      for (int i = 0; i < 4094; i++) tick();
      check("ctr_wrap_at1", ctr_zero, 0);
      tick();
      check("ctr_wrap_at0", ctr_zero, 1);
      cntload_ = 1'b0; d = 12'h000;
      tick();
      check("ctr_load_prio", ctr_zero, 1);
      cntload_ = 1'b1; cnte_ = 1'b1;
      tick();
      check("ctr_hold", ctr_zero, 1);

      // Zero and carry
      zero_ = 1'b0; s = 2'b11; d = 12'hABC; cin = 1'b1; #1;
      check("zero_y", y, 12'h000);
      check("zero_cout", cout, 0);
      tick();
      zero_ = 1'b1; s = 2'b00; #1;
      check("zero_upc", y, 12'h001);
      s = 2'b11; d = 12'hFFF; #1;
      check("carry_y", y, 12'hFFF);
      check("carry_cout", cout, 1);
      tick();
      s = 2'b00; #1;
      check("carry_upc", y, 12'h000);
      check("carry_cout_clr", cout, 0);

      // Async reset mid-run with 2 stack entries and ctr=5
      fe_ = 1'b0; pup = 1'b1; cntload_ = 1'b0; d = 12'h005;
      tick();
      cntload_ = 1'b1;
      tick();
      fe_ = 1'b1; #1;
      check("pre_rst_empty", stk_empty, 0);
      check("pre_rst_ctr", ctr_zero, 0);
      check("pre_rst_y", y, 12'h002);
      #1 rst_ = 1'b0;
      #1;
      check("arst_empty", stk_empty, 1);
      check("arst_ctr_zero", ctr_zero, 1);
      check("arst_y", y, 0);
      check("arst_err", stk_err, 0);
      @(negedge clk);
      rst_ = 1'b1;
      s = 2'b10; #1;
      check("arst_tos", y, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/am2911_seq.md
# am2911_seq

Microprogram sequencer datapath with an integrated loop counter. It sits directly downstream of the am29811a next-address control unit and consumes its outputs: `s` selects the next-address source, `fe_`/`pup` drive the subroutine stack, and `cntload_`/`cnte_` drive the loop counter. `ctr_zero` is fed back through the external condition multiplexer to am29811a `test`. The `mape_`/`ple_` enables select the external source that drives `d`.

## Interface
Parameters:
- WIDTH, 12, microaddress width
- CWIDTH, 12, loop counter width (CWIDTH ≤ WIDTH)
- DEPTH, 4, stack entries (power of two)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_  in  1  asynchronous reset, active-low
- s  in  2  source select: 00 uPC, 01 register R, 10 top of stack, 11 direct `d`
- fe_  in  1  stack file enable, active-low
- pup  in  1  stack direction: 1 push, 0 pop
- re_  in  1  register R load enable, active-low
- zero_  in  1  forces `y` to 0, active-low
- cin  in  1  incrementer carry-in
- cntload_  in  1  counter load, active-low
- cnte_  in  1  counter decrement enable, active-low
- d  in  WIDTH  direct address / counter load data
- y  out  WIDTH  next microaddress, combinational
- cout  out  1  incrementer carry-out
- ctr_zero  out  1  counter == 0
- stk_empty  out  1  no stack entries
- stk_full  out  1  DEPTH entries held
- stk_err  out  1  sticky stack fault (see Configuration)

## Operation
- `y` = 0 when `zero_`=0. Otherwise `y` = mux(s): uPC, R, TOS, or `d`. With an empty stack, TOS reads 0.
- uPC ← `y` + `cin`. `cout` is the carry out of that WIDTH-bit add; `y`=all-ones with `cin`=1 gives 0 and `cout`=1.
- R ← `d` when `re_`=0; otherwise R holds.
- Push (`fe_`=0, `pup`=1):
  - The pre-edge uPC is stored at sp+1 and sp increments.
  - When full, sp wraps and the oldest entry is overwritten; the count stays at DEPTH.
- Pop (`fe_`=0, `pup`=0): sp decrements. Pop when empty leaves the stack empty.
- `fe_`=1: stack unchanged.
- `s`=10 combined with a pop: `y` shows the TOS before the pop.
- `s`=10 combined with a push: `y` shows the old TOS, and the push stores uPC.
- Counter:
  - `cntload_`=0: ctr ← `d`[CWIDTH-1:0]. Load has priority over decrement.
  - `cntload_`=1 and `cnte_`=0: ctr ← ctr−1, wrapping from 0 to all-ones.
  - Otherwise ctr holds.
- `ctr_zero`, `stk_empty`, `stk_full` are combinational decodes of registered state.

## Timing
- Zero-latency combinational paths: `s`, `zero_`, `d`, and state → `y`/`cout`. There is no path from inputs to state other than through clk.
- Single-cycle updates of uPC, R, stack, and ctr on the rising clk edge.
- Reset values, applied asynchronously while `rst_`=0:
  - uPC = 0, R = 0, ctr = 0, stack empty (count 0, entries 0), `stk_err` = 0.
  - Hence `ctr_zero`=1, `stk_empty`=1, `stk_full`=0.
  - `y`=0 for `s`∈{00,01,10}.
- Reset asserted mid-operation discards all state immediately; no edge is required.
- Release of `rst_` is synchronous to the design's use. The first state update happens on the first clk edge with `rst_`=1.

## Configuration
- Macro: `AM2911_SEQ_STKCHK_EN`.
- Defined:
  - `stk_err` is set by a push while full or a pop while empty.
  - It stays set until reset.
  - Wrap/overwrite behaviour is unchanged.
- Undefined: `stk_err` is tied to 0 and no check logic is built.

## Structure
- Package `am2911_seq_pkg`:
  - Source-select constants: S_UPC=2'b00, S_REG=2'b01, S_STK=2'b10, S_D=2'b11.
  - Stack-op encoding constants.
- Sub-module `am2911_seq_stack`:
  - Parameterised LIFO (DEPTH×WIDTH) with push/pop, TOS read, occupancy count, full/empty, and optional error flag.
- The top level holds the mux, incrementer, uPC, R, and counter.

## Test plan
1. Sequential fetch: reset, then `s`=00, `cin`=1, 3 clocks → `y` = 0x000, 0x001, 0x002, 0x003.
2. Call/return:
   - Call: uPC=0x006, `s`=11, `d`=0x100, `fe_`=0, `pup`=1 → `y`=0x100; after the edge uPC=0x101, TOS=0x006, `stk_empty`=0.
   - Return: `s`=10, `fe_`=0, `pup`=0 → `y`=0x006; after the edge uPC=0x007, `stk_empty`=1.
3. Stack overflow:
   - 4 pushes → `stk_full`=1.
   - 5th push → `stk_err`=1 with the macro (0 without), and TOS = the 5th pushed uPC.
4. Loop counter:
   - `cntload_`=0, `d`=0x003, clock → `ctr_zero`=0.
   - `cnte_`=0 for 3 clocks → `ctr_zero`=1.
   - 4th clock → ctr=0xFFF, `ctr_zero`=0.
   - Load with `cnte_`=0 simultaneously → the load wins.
5. Zero and carry:
   - `zero_`=0, `s`=11, `d`=0xABC, `cin`=1 → `y`=0x000; uPC=0x001 after the edge.
   - `s`=11, `d`=0xFFF, `cin`=1 → `cout`=1; uPC=0x000.
6. Async reset mid-run: stack holds 2 entries and ctr=5; pulse `rst_` low between edges → immediately `stk_empty`=1, `ctr_zero`=1, and `y`=0 with `s`=00.
